// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the mixer's I2S transmit path.
//   SAMPLE_W   : width of one audio sample (two's complement)
//   SLOT_BITS  : bclk periods per I2S channel slot
//   FRAME_BITS : bclk periods per stereo frame (left + right slot)
//   I2S_OFFSET : data starts one bclk after the lrclk transition
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int I2S_OFFSET = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/i2s_sample_tx_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO holding samples waiting for their I2S frame.
// Full and empty are registered and computed from the next-state count.
// A push while full is only taken when a pop happens in the same cycle.
//   clk, reset : system clock, synchronous active-high reset
//   push_i     : write din_i this cycle
//   pop_i      : consume the head entry this cycle (ignored when empty)
//   din_i      : data to write
//   dout_o     : head entry (valid when empty_o is low)
//   full_o     : FIFO holds DEPTH entries
//   empty_o    : FIFO holds no entries
//   count_o    : number of stored entries
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import audio_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Next-state pointers, count and flags; power-of-two depth lets pointers wrap naturally
  always_comb begin
    wr_en_s  = push_i && (!full_q || pop_i);
    rd_en_s  = pop_i && !empty_q;
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == CNT_W'(0));
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule : sample_fifo

// File: rtl/i2s_sample_tx.sv
// -----------------------------------------------------------------------------
// i2s_sample_tx
// Serialises the mixer's mono sample stream as I2S stereo frames; each sample
// is sent in both the left and right slot, MSB first, one bclk after lrclk.
//   clk, reset : system clock, synchronous active-high reset
//   in_data    : signed sample, taken when in_valid is high and room exists
//   in_valid   : one sample per asserted cycle
//   in_ready   : FIFO not full (registered)
//   on         : 1 = transmit, 0 = mute (FIFO keeps draining)
//   bclk       : bit clock, period 2*BCLK_DIV clk
//   lrclk      : word select, 0 = left slot, 1 = right slot
//   sdata      : serial data, changes on bclk falling edges
//   underflow  : one-cycle pulse when a frame starts with no sample queued
//   overflow   : one-cycle pulse when an incoming sample is dropped
// -----------------------------------------------------------------------------
module i2s_sample_tx #(
  parameter int SAMPLE_W   = 24,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       on,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata,
  output logic                       underflow,
  output logic                       overflow
);
  import audio_pkg::*;

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int POS_W = $clog2(SLOT_BITS);
  localparam int IDX_W = $clog2(SAMPLE_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] shadow_q, shadow_d;
  logic                underflow_q, underflow_d;
  logic                overflow_q, overflow_d;
  logic                in_ready_q, in_ready_d;

  logic                div_tc_s;
  logic                fall_s;
  logic                wrap_s;
  logic                push_s;
  logic                pop_s;
  logic [BIT_W-1:0]    bit_next_s;
  logic [POS_W-1:0]    pos_s;
  logic [IDX_W-1:0]    idx_s;
  logic                slot_bit_s;
  logic [CNT_W-1:0]    count_next_s;
  logic [SAMPLE_W-1:0] fifo_dout_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (in_data),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Divider, frame sequencing, FIFO handshakes and serial bit selection
  always_comb begin
    div_tc_s   = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fall_s     = div_tc_s && bclk_q;
    bit_next_s = bit_cnt_q + BIT_W'(1);
    // The frame boundary is the fall event that takes bit_cnt from its last value back to 0
    wrap_s     = fall_s && (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
    pop_s      = wrap_s && !fifo_empty_s;
    // A full FIFO still takes a sample when the head leaves in the same cycle
    push_s     = in_valid && (!fifo_full_s || pop_s);

    // Slot position p of the bit going out next: p=0 is the delay bit, then MSB..LSB, then padding
    pos_s      = bit_next_s[POS_W-1:0];
    idx_s      = '0;
    slot_bit_s = 1'b0;
    if ((int'(pos_s) >= I2S_OFFSET) && (int'(pos_s) < (I2S_OFFSET + SAMPLE_W))) begin
      idx_s      = IDX_W'(SAMPLE_W + I2S_OFFSET - 1 - int'(pos_s));
      slot_bit_s = shadow_q[idx_s];
    end else begin
      slot_bit_s = 1'b0;
    end

    div_cnt_d = div_tc_s ? '0 : (div_cnt_q + DIV_W'(1));
    bclk_d    = div_tc_s ? ~bclk_q : bclk_q;

    if (fall_s) begin
      bit_cnt_d = bit_next_s;
      lrclk_d   = bit_next_s[BIT_W-1];
      sdata_d   = slot_bit_s;
    end else begin
      bit_cnt_d = bit_cnt_q;
      lrclk_d   = lrclk_q;
      sdata_d   = sdata_q;
    end

    // Shadow is reloaded only at the frame boundary so both slots carry the same value
    if (wrap_s) begin
      if (pop_s && on) begin
        shadow_d = fifo_dout_s;
      end else begin
        shadow_d = '0;
      end
    end else begin
      shadow_d = shadow_q;
    end

    underflow_d  = wrap_s && fifo_empty_s;
    overflow_d   = in_valid && fifo_full_s && !pop_s;
    count_next_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    in_ready_d   = (count_next_s != CNT_W'(FIFO_DEPTH));
  end

  // Output and state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= BIT_W'(FRAME_BITS - 1);
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      shadow_q    <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      shadow_q    <= shadow_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;
  assign in_ready  = in_ready_q;

endmodule : i2s_sample_tx

// File: tb/tb_i2s_sample_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_sample_tx
// Self-checking bench for i2s_sample_tx. A frame-level reference model
// (sample queue, cycle arithmetic for bclk/lrclk/slot positions) predicts all
// outputs every cycle; a vector table and hand-written sequences cover the
// reset, overflow, mute, full-with-pop and mid-frame reset corners.
// -----------------------------------------------------------------------------
module tb_i2s_sample_tx;
  import audio_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int HALF  = 2 * DIV;  // clk cycles per bclk period

  logic    clk = 1'b0;
  logic    reset;
  sample_t in_data;
  logic    in_valid;
  logic    in_ready;
  logic    on;
  logic    bclk;
  logic    lrclk;
  logic    sdata;
  logic    underflow;
  logic    overflow;

  i2s_sample_tx #(
    .SAMPLE_W   (24),
    .BCLK_DIV   (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .on        (on),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: n = clk edges since reset released
  int          n = 0;
  logic [23:0] mq[$];
  logic [23:0] cur;
  logic        e_bclk, e_lr, e_sd, e_rdy, e_uf, e_ov;

  logic [5:0]  got_v;
  logic        cap_sd[64];
  logic        cap_lr[64];
  int          uf_cnt;
  int          uf_t[$];

  typedef struct {
    logic        rst;
    logic        vld;
    logic [23:0] data;
    logic        on;
    logic [5:0]  exp;  // {bclk, lrclk, sdata, in_ready, underflow, overflow}
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", name, got, exp, n, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [23:0] d, input logic o);
    int f, b, p;
    if (r) begin
      n = 0;
      mq.delete();
      cur = '0;
      e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0;
      e_rdy = 1'b1;  e_uf = 1'b0; e_ov = 1'b0;
    end else begin
      n++;
      e_bclk = ((n / DIV) % 2) == 1;
      e_uf   = 1'b0;
      if (n % HALF == 0) begin
        f = n / HALF;
        b = (f - 1) % 64;
        if (b == 0) begin
          if (mq.size() > 0) begin
            cur = mq.pop_front();
            if (!o) cur = '0;
          end else begin
            cur  = '0;
            e_uf = 1'b1;
          end
        end
        e_lr = (b >= 32);
        p    = b % 32;
        e_sd = (p >= 1 && p <= 24) ? cur[24 - p] : 1'b0;
      end
      e_ov = 1'b0;
      if (v) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else e_ov = 1'b1;
      end
      e_rdy = (mq.size() < DEPTH);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [23:0] d, input logic o);
    int b;
    reset = r; in_valid = v; in_data = d; on = o;
    @(posedge clk);
    #1;
    model_step(r, v, d, o);
    got_v = {bclk, lrclk, sdata, in_ready, underflow, overflow};
    chk("model", {26'd0, got_v}, {26'd0, e_bclk, e_lr, e_sd, e_rdy, e_uf, e_ov});
    if (!r && underflow === 1'b1) begin
      uf_cnt++;
      uf_t.push_back(n);
    end
    if (!r && (n % HALF == 0)) begin
      b = ((n / HALF) - 1) % 64;
      cap_sd[b] = sdata;
      cap_lr[b] = lrclk;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 24'h0, 1'b1);
    uf_cnt = 0;
    uf_t.delete();
  endtask

  task automatic idle_until(input int until_n, input logic o);
    while (n < until_n) cycle(1'b0, 1'b0, 24'h0, o);
  endtask

  function automatic logic [23:0] slot_word(input int base);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[23 - i] = cap_sd[base + 1 + i];
    return w;
  endfunction

  function automatic logic frame_any_one();
    logic a;
    a = 1'b0;
    for (int i = 0; i < 64; i++) a = a | cap_sd[i];
    return a;
  endfunction

  initial begin
    int pad, lr_bad, rate;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; on = 1'b1;
    uf_cnt = 0;
    @(negedge clk);

    // --- Table: reset, five back-to-back pushes, overflow, first load ---
    tbl[0] = '{1'b1, 1'b0, 24'h000000, 1'b1, 6'b000100};
    tbl[1] = '{1'b0, 1'b1, 24'h800001, 1'b1, 6'b000100};
    tbl[2] = '{1'b0, 1'b1, 24'h7FFFFF, 1'b1, 6'b000100};
    tbl[3] = '{1'b0, 1'b1, 24'hABCDEF, 1'b1, 6'b000100};
    tbl[4] = '{1'b0, 1'b1, 24'h123456, 1'b1, 6'b100000};
    tbl[5] = '{1'b0, 1'b1, 24'h555555, 1'b1, 6'b100001};
    tbl[6] = '{1'b0, 1'b0, 24'h000000, 1'b1, 6'b100000};
    tbl[7] = '{1'b0, 1'b0, 24'h000000, 1'b1, 6'b100000};
    tbl[8] = '{1'b0, 1'b0, 24'h000000, 1'b1, 6'b000100};
    tbl[9] = '{1'b0, 1'b0, 24'h000000, 1'b1, 6'b000100};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].on);
      chk($sformatf("tbl[%0d]", i), {26'd0, got_v}, {26'd0, tbl[i].exp});
    end
    // Four queued samples cover frames 0..3; frame 4 underflows
    uf_cnt = 0;
    idle_until(2100, 1'b1);
    chk("burst_uf_count", uf_cnt, 1);

    // --- Single sample 0x800001: frame layout ---
    do_reset();
    cycle(1'b0, 1'b1, 24'h800001, 1'b1);
    idle_until(512, 1'b1);
    chk("frame_left", slot_word(0), 24'h800001);
    chk("frame_right", slot_word(32), 24'h800001);
    pad = 0; lr_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if ((i % 32 == 0 || i % 32 > 24) && cap_sd[i] !== 1'b0) pad++;
      if (cap_lr[i] !== (i >= 32)) lr_bad++;
    end
    chk("frame_pad_zeros", pad, 0);
    chk("frame_lrclk", lr_bad, 0);
    chk("frame_no_uf", uf_cnt, 0);

    // --- No input: underflow once per frame, 512 clk apart ---
    do_reset();
    idle_until(1100, 1'b1);
    chk("idle_uf_count", uf_cnt, 3);
    if (uf_t.size() >= 2) begin
      chk("idle_uf_first", uf_t[0], 8);
      chk("idle_uf_spacing", uf_t[1] - uf_t[0], 512);
    end else begin
      chk("idle_uf_times", uf_t.size(), 2);
    end

    // --- Mute at load: frame silent, entry consumed, no underflow ---
    do_reset();
    cycle(1'b0, 1'b1, 24'h7FFFFF, 1'b0);
    idle_until(8, 1'b0);
    idle_until(512, 1'b1);
    chk("mute_frame_zero", frame_any_one(), 1'b0);
    chk("mute_no_uf", uf_cnt, 0);
    idle_until(530, 1'b1);
    chk("mute_consumed_uf", uf_cnt, 1);

    // --- Full FIFO with in_valid held across the load event ---
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 24'h100000 + 24'(i), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 24'h0F0F0F, 1'b1);
    chk("full_pop_no_ovf", overflow, 1'b0);
    chk("full_pop_ready", in_ready, 1'b0);
    idle_until(40, 1'b1);

    // --- Reset mid-frame at bit_cnt = 10 ---
    do_reset();
    cycle(1'b0, 1'b1, 24'hABCDEF, 1'b1);
    idle_until(90, 1'b1);
    do_reset();
    chk("midrst_outputs", {26'd0, got_v}, {26'd0, 6'b000100});
    idle_until(512, 1'b1);
    chk("midrst_zero_frame", frame_any_one(), 1'b0);
    chk("midrst_uf", uf_cnt, 1);

    // --- Randomised traffic against the model ---
    do_reset();
    rate = 1;
    for (int c = 0; c < 6000; c++) begin
      if (c % 512 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 0;
          1: rate = 1;
          2: rate = 5;
          default: rate = 50;
        endcase
      end
      cycle(($urandom_range(0, 2999) == 0),
            ($urandom_range(0, 99) < rate),
            24'($urandom),
            ($urandom_range(0, 9) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_i2s_sample_tx
